// File: rtl/tlb_issue.sv
// tlb_issue -- sequencer for MIPS-style TLB instructions (TLBP/TLBR/TLBWI/TLBWR).
//
// An accepted instruction's operands are latched. The instruction is then
// presented to the TLB until the TLB reports completion. The results are
// returned to CP0 in a single writeback cycle. The block also maintains the
// CP0 Random register, which TLBWR uses as its target entry.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   op_valid/op_code/op_ready   instruction handshake (0=TLBP 1=TLBR 2=TLBWI 3=TLBWR)
//   cp0_index, cp0_entryhi,
//   cp0_entrylo0/1              CP0 operands sampled at acceptance
//   cp0_wired, cp0_wired_we     Wired register value and its write strobe
//   tlb_req, tlb_index,
//   tlb_entryhi/lo0/lo1         request to the TLB (0=none, 1..4 = op+1)
//   tlb_ok, res_*               TLB completion and its results
//   wb_valid, wb_index_we,
//   wb_entry_we, wb_*           one-cycle writeback to CP0
//   random                      CP0 Random
//   busy                        an instruction is in flight
module tlb_issue #(
  parameter int TLBEntries = 32,
  localparam int IW = $clog2(TLBEntries)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          op_valid,
  input  logic [1:0]    op_code,
  output logic          op_ready,
  input  logic [IW-1:0] cp0_index,
  input  logic [31:0]   cp0_entryhi,
  input  logic [31:0]   cp0_entrylo0,
  input  logic [31:0]   cp0_entrylo1,
  input  logic [IW-1:0] cp0_wired,
  input  logic          cp0_wired_we,
  output logic [2:0]    tlb_req,
  output logic [IW-1:0] tlb_index,
  output logic [31:0]   tlb_entryhi,
  output logic [31:0]   tlb_entrylo0,
  output logic [31:0]   tlb_entrylo1,
  input  logic          tlb_ok,
  input  logic [31:0]   res_index,
  input  logic [31:0]   res_entryhi,
  input  logic [31:0]   res_entrylo0,
  input  logic [31:0]   res_entrylo1,
  output logic          wb_valid,
  output logic          wb_index_we,
  output logic          wb_entry_we,
  output logic [31:0]   wb_index,
  output logic [31:0]   wb_entryhi,
  output logic [31:0]   wb_entrylo0,
  output logic [31:0]   wb_entrylo1,
  output logic [IW-1:0] random,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [1:0]    OpTlbp  = 2'd0;
  localparam logic [1:0]    OpTlbr  = 2'd1;
  localparam logic [1:0]    OpTlbwr = 2'd3;
  localparam logic [IW-1:0] LastIdx = IW'(TLBEntries - 1);

  state_t        state, state_next;
  logic [1:0]    op_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   hi_q, lo0_q, lo1_q;
  logic [31:0]   res_index_q, res_hi_q, res_lo0_q, res_lo1_q;
  logic [IW-1:0] random_q, random_next;
  logic          unused_res_bits;

  // Result bits that the CP0 field masks throw away; folded together so
  // their non-use is deliberate.
  assign unused_res_bits = ^{res_index[30:IW], res_entryhi[12:8],
                             res_entrylo0[31:26], res_entrylo1[31:26]};

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next state and all handshake/writeback outputs. Writeback data is
  // zero except in the WB cycle of the op that produces it.
  always_comb begin
    state_next  = state;
    op_ready    = 1'b0;
    tlb_req     = 3'd0;
    wb_valid    = 1'b0;
    wb_index_we = 1'b0;
    wb_entry_we = 1'b0;
    wb_index    = 32'd0;
    wb_entryhi  = 32'd0;
    wb_entrylo0 = 32'd0;
    wb_entrylo1 = 32'd0;
    unique case (state)
      IDLE: begin
        op_ready = resetn;
        if (op_valid) state_next = REQ;
      end
      REQ: begin
        tlb_req = {1'b0, op_q} + 3'd1;
        if (tlb_ok) state_next = WB;
      end
      WB: begin
        wb_valid   = 1'b1;
        state_next = IDLE;
        if (op_q == OpTlbp) begin
          wb_index_we = 1'b1;
          wb_index    = res_index_q;
        end
        if (op_q == OpTlbr) begin
          wb_entry_we = 1'b1;
          wb_entryhi  = res_hi_q;
          wb_entrylo0 = res_lo0_q;
          wb_entrylo1 = res_lo1_q;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Random counts down and wraps to the top entry once it reaches the
  // wired boundary. A Wired write restarts it from the top. If the wired
  // region covers everything, the wrap condition holds every cycle, so the
  // counter pins at the top.
  always_comb begin
    random_next = random_q - IW'(1);
    if (cp0_wired_we || (random_q <= cp0_wired)) random_next = LastIdx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) random_q <= LastIdx;
    else         random_q <= random_next;
  end

  // Operand capture on acceptance. The result is captured already masked
  // into CP0 field layout. A probe miss keeps only the P bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q        <= 2'd0;
      idx_q       <= '0;
      hi_q        <= 32'd0;
      lo0_q       <= 32'd0;
      lo1_q       <= 32'd0;
      res_index_q <= 32'd0;
      res_hi_q    <= 32'd0;
      res_lo0_q   <= 32'd0;
      res_lo1_q   <= 32'd0;
    end else begin
      if ((state == IDLE) && op_valid) begin
        op_q  <= op_code;
        idx_q <= (op_code == OpTlbwr) ? random_q : cp0_index;
        hi_q  <= cp0_entryhi;
        lo0_q <= cp0_entrylo0;
        lo1_q <= cp0_entrylo1;
      end
      if ((state == REQ) && tlb_ok) begin
        res_index_q <= {res_index[31], {(31-IW){1'b0}},
                        res_index[31] ? {IW{1'b0}} : res_index[IW-1:0]};
        res_hi_q    <= {res_entryhi[31:13], 5'd0, res_entryhi[7:0]};
        res_lo0_q   <= {6'd0, res_entrylo0[25:0]};
        res_lo1_q   <= {6'd0, res_entrylo1[25:0]};
      end
    end
  end

  assign tlb_index    = idx_q;
  assign tlb_entryhi  = hi_q;
  assign tlb_entrylo0 = lo0_q;
  assign tlb_entrylo1 = lo1_q;
  assign random       = random_q;
  assign busy         = (state != IDLE);

endmodule
